// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the backup-RAM sector responder: sector geometry,
// the fill value returned for out-of-range sectors, the responder FSM state
// encoding and a small word-counter helper.
// ---------------------------------------------------------------------------
package bram_pkg;

  localparam int          SECTOR_WORDS = 256;
  localparam int          WORD_BITS    = $clog2(SECTOR_WORDS);
  localparam logic [15:0] OOR_FILL     = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_REQ  = 4'd1,
    RD_WAIT = 4'd2,
    RD_PUT  = 4'd3,
    WR_ADDR = 4'd4,
    WR_LAT  = 4'd5,
    WR_REQ  = 4'd6,
    WR_WAIT = 4'd7,
    DONE    = 4'd8
  } bram_state_t;

  // Word counter carries one extra bit so the last word wraps into the MSB,
  // which is what terminates the per-sector loop.
  function automatic logic [WORD_BITS:0] next_word(input logic [WORD_BITS:0] w);
    return w + {{WORD_BITS{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/toggle_req_port.sv
// ---------------------------------------------------------------------------
// toggle_req_port
// Initiator side of a ddram-style toggle handshake. One access is started by
// flipping o_mem_req; the access is complete once the memory side mirrors it
// on i_mem_ack. An issue request is ignored while an access is outstanding,
// so the request line can never run ahead of the acknowledge.
//
// Ports:
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset (forces o_mem_req to 0)
//   i_issue    start one access this cycle (honoured only when o_done)
//   i_mem_ack  acknowledge toggle from the memory side
//   o_mem_req  request toggle toward the memory side (registered)
//   o_done     no access outstanding (i_mem_ack == o_mem_req)
// ---------------------------------------------------------------------------
module toggle_req_port (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_issue,
  input  logic i_mem_ack,
  output logic o_mem_req,
  output logic o_done
);

  logic r_req;

  assign o_done    = (i_mem_ack == r_req);
  assign o_mem_req = r_req;

  // Request toggle register: flips once per accepted issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req <= 1'b0;
    end else if (i_issue && o_done) begin
      r_req <= ~r_req;
    end else begin
      r_req <= r_req;
    end
  end

endmodule

// File: rtl/bram_sector_server.sv
// ---------------------------------------------------------------------------
// bram_sector_server
// Responder for the save/load sequencer's sector handshake. Serves 512-byte
// sectors (256 x 16-bit words) from a word-addressed backing store reached
// through a toggle req/ack port. Sectors beyond 2^LBA_BITS are flagged in the
// sticky range_err, read back as OOR_FILL and never touch the store.
//
// Ports:
//   clk_sys, RESET_N               clock, async active-low reset
//   sd_lba, sd_rd, sd_wr           sector request (read wins if both high)
//   sd_ack                         high for the whole sector transfer
//   sd_buff_addr/dout/wr/din       initiator buffer word port
//   mem_addr/dout/we/req/ack/din   backing-store toggle port
//   busy                           FSM not idle
//   range_err                      sticky out-of-range flag
// ---------------------------------------------------------------------------
module bram_sector_server
  import bram_pkg::*;
#(
  parameter int LBA_BITS = 7,
  parameter int DIN_LAT  = 2
) (
  input  logic                  clk_sys,
  input  logic                  RESET_N,
  input  logic [31:0]           sd_lba,
  input  logic                  sd_rd,
  input  logic                  sd_wr,
  output logic                  sd_ack,
  output logic [7:0]            sd_buff_addr,
  output logic [15:0]           sd_buff_dout,
  output logic                  sd_buff_wr,
  input  logic [15:0]           sd_buff_din,
  output logic [LBA_BITS+7:0]   mem_addr,
  output logic [15:0]           mem_dout,
  output logic                  mem_we,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_din,
  output logic                  busy,
  output logic                  range_err
);

  // Last value of the write-latency counter before sd_buff_din is captured.
  localparam logic [1:0] LAT_LAST = 2'(DIN_LAT - 1);

  bram_state_t            r_state, w_nxt_state;
  logic [LBA_BITS-1:0]    r_lba, w_nxt_lba;
  logic                   r_oor, w_nxt_oor;
  logic [WORD_BITS:0]     r_word, w_nxt_word;
  logic [1:0]             r_lat, w_nxt_lat;
  logic                   r_ack, w_nxt_ack;
  logic [7:0]             r_buff_addr, w_nxt_buff_addr;
  logic [15:0]            r_buff_dout, w_nxt_buff_dout;
  logic                   r_buff_wr, w_nxt_buff_wr;
  logic [LBA_BITS+7:0]    r_mem_addr, w_nxt_mem_addr;
  logic [15:0]            r_mem_dout, w_nxt_mem_dout;
  logic                   r_mem_we, w_nxt_mem_we;
  logic                   r_busy, w_nxt_busy;
  logic                   r_range_err, w_nxt_range_err;
  logic                   w_issue;
  logic                   w_mem_done;

  toggle_req_port u_req (
    .i_clk     (clk_sys),
    .i_rst_n   (RESET_N),
    .i_issue   (w_issue),
    .i_mem_ack (mem_ack),
    .o_mem_req (mem_req),
    .o_done    (w_mem_done)
  );

  // Next-state and next-output logic for the sector transfer FSM.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_lba       = r_lba;
    w_nxt_oor       = r_oor;
    w_nxt_word      = r_word;
    w_nxt_lat       = r_lat;
    w_nxt_ack       = r_ack;
    w_nxt_buff_addr = r_buff_addr;
    w_nxt_buff_dout = r_buff_dout;
    w_nxt_buff_wr   = 1'b0;
    w_nxt_mem_addr  = r_mem_addr;
    w_nxt_mem_dout  = r_mem_dout;
    w_nxt_mem_we    = r_mem_we;
    w_nxt_range_err = r_range_err;
    w_issue         = 1'b0;

    case (r_state)
      IDLE: begin
        // Waiting for ack == req also re-synchronises after a reset that
        // landed while the store still had an access in flight.
        if ((sd_rd || sd_wr) && w_mem_done) begin
          w_nxt_lba       = sd_lba[LBA_BITS-1:0];
          w_nxt_oor       = |sd_lba[31:LBA_BITS];
          w_nxt_range_err = r_range_err | w_nxt_oor;
          w_nxt_word      = '0;
          w_nxt_buff_addr = 8'd0;
          w_nxt_ack       = 1'b1;
          w_nxt_state     = sd_rd ? RD_REQ : WR_ADDR;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      RD_REQ: begin
        w_nxt_mem_addr = {r_lba, r_word[WORD_BITS-1:0]};
        w_nxt_mem_we   = 1'b0;
        w_issue        = ~r_oor;
        w_nxt_state    = RD_WAIT;
      end
      RD_WAIT: begin
        // With no access issued (out of range) this falls straight through.
        if (w_mem_done) begin
          w_nxt_buff_addr = r_word[WORD_BITS-1:0];
          w_nxt_buff_dout = r_oor ? OOR_FILL : mem_din;
          w_nxt_buff_wr   = 1'b1;
          w_nxt_state     = RD_PUT;
        end else begin
          w_nxt_state = RD_WAIT;
        end
      end
      RD_PUT: begin
        w_nxt_word = next_word(r_word);
        if (w_nxt_word[WORD_BITS]) begin
          w_nxt_ack   = 1'b0;
          w_nxt_state = DONE;
        end else begin
          w_nxt_state = RD_REQ;
        end
      end
      WR_ADDR: begin
        w_nxt_lat   = 2'd0;
        w_nxt_state = WR_LAT;
      end
      WR_LAT: begin
        if (r_lat == LAT_LAST) begin
          w_nxt_mem_dout = sd_buff_din;
          w_nxt_state    = WR_REQ;
        end else begin
          w_nxt_lat   = r_lat + 2'd1;
          w_nxt_state = WR_LAT;
        end
      end
      WR_REQ: begin
        w_nxt_mem_addr = {r_lba, r_word[WORD_BITS-1:0]};
        w_nxt_mem_we   = 1'b1;
        w_issue        = ~r_oor;
        w_nxt_state    = WR_WAIT;
      end
      WR_WAIT: begin
        if (w_mem_done) begin
          w_nxt_word = next_word(r_word);
          if (w_nxt_word[WORD_BITS]) begin
            w_nxt_ack   = 1'b0;
            w_nxt_state = DONE;
          end else begin
            // Buffer address stays on word 255 after the final word.
            w_nxt_buff_addr = w_nxt_word[WORD_BITS-1:0];
            w_nxt_state     = WR_ADDR;
          end
        end else begin
          w_nxt_state = WR_WAIT;
        end
      end
      DONE: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_ack   = 1'b0;
        w_nxt_state = IDLE;
      end
    endcase

    w_nxt_busy = (w_nxt_state != IDLE);
  end

  // State and registered-output update.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_lba       <= '0;
      r_oor       <= 1'b0;
      r_word      <= '0;
      r_lat       <= 2'd0;
      r_ack       <= 1'b0;
      r_buff_addr <= 8'd0;
      r_buff_dout <= 16'd0;
      r_buff_wr   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_dout  <= 16'd0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_lba       <= w_nxt_lba;
      r_oor       <= w_nxt_oor;
      r_word      <= w_nxt_word;
      r_lat       <= w_nxt_lat;
      r_ack       <= w_nxt_ack;
      r_buff_addr <= w_nxt_buff_addr;
      r_buff_dout <= w_nxt_buff_dout;
      r_buff_wr   <= w_nxt_buff_wr;
      r_mem_addr  <= w_nxt_mem_addr;
      r_mem_dout  <= w_nxt_mem_dout;
      r_mem_we    <= w_nxt_mem_we;
      r_busy      <= w_nxt_busy;
      r_range_err <= w_nxt_range_err;
    end
  end

  assign sd_ack       = r_ack;
  assign sd_buff_addr = r_buff_addr;
  assign sd_buff_dout = r_buff_dout;
  assign sd_buff_wr   = r_buff_wr;
  assign mem_addr     = r_mem_addr;
  assign mem_dout     = r_mem_dout;
  assign mem_we       = r_mem_we;
  assign busy         = r_busy;
  assign range_err    = r_range_err;

endmodule
